// File: rtl/adda_pkg.sv
// +--------------------------------------------------------------------+
// | adda_pkg : shared SPI FSM states and timing defaults for AD/DA     |
// | Rev 1.0  : initial release                                         |
// +--------------------------------------------------------------------+
`default_nettype none

package adda_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } adda_state_e;

  localparam int unsigned C_CLK_DIV = 4;
  localparam int unsigned C_GAP     = 8;

endpackage

`default_nettype wire

// File: rtl/spi_clk_gen.sv
// +--------------------------------------------------------------------+
// | spi_clk_gen : half-period divider producing sclk plus edge strobes |
// | Rev 1.0     : initial release                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module spi_clk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          wrap;

  // Strobes flag the clk edge on which sclk_q is about to toggle.
  assign wrap   = en_i && (cnt_q == CW'(CLK_DIV - 1));
  assign rise_o = wrap && !sclk_q;
  assign fall_o = wrap && sclk_q;
  assign sclk_o = sclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en_i) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (wrap) begin
      cnt_d  = '0;
      sclk_d = !sclk_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_adc_rx.sv
// +--------------------------------------------------------------------+
// | spi_adc_rx : SPI read master, one fixed-length ADC frame per start |
// | Rev 1.0    : initial release                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module spi_adc_rx
  import adda_pkg::*;
#(
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned FRAME_W = 16,
  parameter int unsigned LEAD    = 2,
  parameter int unsigned CLK_DIV = C_CLK_DIV,
  parameter int unsigned GAP     = C_GAP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              cs_n,
  output logic              sclk,
  input  logic              miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid
);

  localparam int unsigned TMR_MAX = (CLK_DIV > GAP) ? CLK_DIV : GAP;
  localparam int unsigned TW      = $clog2(TMR_MAX);
  localparam int unsigned BW      = $clog2(FRAME_W + 1);

  adda_state_e        state_q, state_d;
  logic [TW-1:0]      tmr_q, tmr_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [FRAME_W-1:0] sreg_q, sreg_d;
  logic [DATA_W-1:0]  rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               busy_q, busy_d;
  logic               cs_n_q, cs_n_d;
  logic               sclk_rise, sclk_fall;
  logic               unused_sreg;

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (state_q == SHIFT),
    .sclk_o(sclk),
    .rise_o(sclk_rise),
    .fall_o(sclk_fall)
  );

  // Leading and trailing frame bits are shifted through but never extracted.
  assign unused_sreg = ^sreg_q;

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    bit_d      = bit_q;
    sreg_d     = sreg_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;

    if (sclk_rise) begin
      sreg_d = {sreg_q[FRAME_W-2:0], miso};
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          tmr_d   = '0;
        end
      end
      SETUP: begin
        if (tmr_q == TW'(CLK_DIV - 1)) begin
          state_d = SHIFT;
          tmr_d   = '0;
          bit_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      SHIFT: begin
        // The frame ends on the falling edge that closes the last sclk period.
        if (sclk_fall) begin
          if (bit_q == BW'(FRAME_W - 1)) begin
            state_d    = HOLD;
            bit_d      = '0;
            rx_data_d  = sreg_q[FRAME_W-1-LEAD -: DATA_W];
            rx_valid_d = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (tmr_q == TW'(GAP - 1)) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    cs_n_d = !((state_d == SETUP) || (state_d == SHIFT));
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      bit_q      <= '0;
      sreg_q     <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      cs_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      bit_q      <= bit_d;
      sreg_q     <= sreg_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
      cs_n_q     <= cs_n_d;
    end
  end

  assign busy     = busy_q;
  assign cs_n     = cs_n_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_adc_rx.sv
// +--------------------------------------------------------------------+
// | tb_spi_adc_rx : scoreboard bench with a behavioural ADC model      |
// | Rev 1.0       : initial release                                    |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_spi_adc_rx;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        miso  = 1'b0;
  logic        busy, cs_n, sclk, rx_valid;
  logic [11:0] rx_data;

  typedef struct {
    logic [11:0] data;
    int          at;
  } exp_t;

  exp_t        sbq[$];
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;
  int          t0     = 0;
  logic [15:0] adc_frame = 16'h0000;
  int          bit_idx   = 0;

  spi_adc_rx dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .busy    (busy),
    .cs_n    (cs_n),
    .sclk    (sclk),
    .miso    (miso),
    .rx_data (rx_data),
    .rx_valid(rx_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: first bit presented as cs_n falls, the rest on sclk falling edges.
  always @(negedge cs_n) begin
    bit_idx = 0;
    miso    = adc_frame[15];
  end
  always @(negedge sclk) begin
    if (!cs_n && bit_idx < 15) begin
      bit_idx = bit_idx + 1;
      miso    = adc_frame[15-bit_idx];
    end
  end

  task automatic check(input string name, input bit ok,
                       input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every rx_valid and tracks sclk / cs_n shape.
  int   rises     = 0;
  int   hi_run    = 0;
  logic prev_sclk = 1'b0;
  logic prev_cs   = 1'b1;
  always @(negedge clk) begin
    exp_t e;
    if (cs_n) begin
      hi_run++;
    end else begin
      if (prev_cs) check("cs_n_gap", hi_run >= 8, hi_run, 8);
      hi_run = 0;
    end
    prev_cs = cs_n;
    if (!rst_n) begin
      rises     = 0;
      prev_sclk = 1'b0;
    end else begin
      if (sclk && !prev_sclk) rises++;
      prev_sclk = sclk;
      if (rx_valid) begin
        if (sbq.size() == 0) begin
          check("unexpected_rx_valid", 1'b0, rx_data, 0);
        end else begin
          e = sbq.pop_front();
          check("rx_data", rx_data == e.data, rx_data, e.data);
          check("rx_valid_cycle", cyc == e.at, cyc, e.at);
          check("sclk_rises", rises == 16, rises, 16);
        end
        rises = 0;
      end
    end
  end

  // Called at a negedge; start is high for the current cycle, which becomes T0.
  task automatic launch(input logic [15:0] f, input bit expect_rx, input logic [11:0] exp);
    exp_t item;
    adc_frame = f;
    start     = 1'b1;
    t0        = cyc;
    if (expect_rx) begin
      item.data = exp;
      item.at   = t0 + 133;
      sbq.push_back(item);
    end
    @(negedge clk);
    start = 1'b0;
    check("busy_cs_at_T0p1", busy && !cs_n, {busy, cs_n}, 2'b10);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && busy; i++) @(negedge clk);
    check("busy_fall_cycle", !busy && cyc == t0 + 141, cyc - t0, 141);
  endtask

  task automatic wait_until(input int c);
    for (int i = 0; i < 500 && cyc < c; i++) @(negedge clk);
  endtask

  task automatic pulse_at(input int c);
    wait_until(c);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int bad;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {busy, cs_n, sclk, rx_valid} == 4'b0100,
          {busy, cs_n, sclk, rx_valid}, 4'b0100);
    check("reset_rx_data", rx_data == 12'h000, rx_data, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    launch(16'h3A5C, 1'b1, 12'hE97);
    wait_idle();
    repeat (4) @(negedge clk);

    launch(16'hFFFF, 1'b1, 12'hFFF);
    wait_idle();
    launch(16'h0000, 1'b1, 12'h000);
    wait_idle();
    repeat (4) @(negedge clk);

    launch(16'h3A5C, 1'b1, 12'hE97);
    pulse_at(t0 + 5);
    pulse_at(t0 + 132);
    pulse_at(t0 + 140);
    wait_idle();
    wait_until(t0 + 150);
    check("start_in_hold_ignored", !busy && cs_n, {busy, cs_n}, 2'b01);

    repeat (10) @(negedge clk);
    launch(16'h3A5C, 1'b0, 12'h000);
    wait_until(t0 + 60);
    check("pre_reset_shape", !cs_n && sclk, {cs_n, sclk}, 2'b01);
    rst_n = 1'b0;
    #1;
    check("async_reset_ctrl", {cs_n, sclk, busy, rx_valid} == 4'b1000,
          {cs_n, sclk, busy, rx_valid}, 4'b1000);
    check("async_reset_rx_data", rx_data == 12'h000, rx_data, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rx_data_after_reset", rx_data == 12'h000, rx_data, 0);
    launch(16'h3A5C, 1'b1, 12'hE97);
    wait_idle();

    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (busy || !cs_n || sclk) bad++;
    end
    check("idle_quiet", bad == 0, bad, 0);
    check("scoreboard_empty", sbq.size() == 0, sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
